cmos_frame_packer: RTL and testbench
====================================

CMOS_FRAME_PACKER -- requirements
Module: cmos_frame_packer

Interface
REQ-001 SHALL have parameter PIX_W, default 16: camera pixel width in bits.
REQ-002 SHALL have parameter MEM_W, default 32: write word width in bits; MEM_W = K*PIX_W with integer K >= 1, otherwise elaboration fails.
REQ-003 SHALL have parameter CNT_W, default 12: width of the window and position counters.
REQ-004 SHALL have parameter SKIP_W, default 4: width of the frame-decimation field.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: ports clk and rst.
REQ-006 clk  in  1  camera pixel clock; all logic on the rising edge.
REQ-007 rst  in  1  asynchronous reset, active high.
REQ-008 cmos_frame_vsync  in  1  frame sync; a rising edge marks frame start.
REQ-009 cmos_frame_href  in  1  line active; a falling edge marks end of line.
REQ-010 cmos_frame_valid  in  1  cmos_frame_data is valid this cycle.
REQ-011 cmos_frame_data  in  PIX_W  pixel.
REQ-012 cfg_h_start, cfg_h_len, cfg_v_start, cfg_v_len  in  CNT_W each  crop window.
REQ-013 cfg_skip  in  SKIP_W  number of frames dropped after each captured frame.
REQ-014 write_req  out  1  frame write request to the frame buffer.
REQ-015 write_req_ack  in  1  frame buffer accepted the request.
REQ-016 write_en  out  1  write_data valid, one-cycle strobe.
REQ-017 write_data  out  MEM_W  packed pixels.
REQ-018 frame_done  out  1  one-cycle pulse at the end of each captured frame.
REQ-019 frame_cnt  out  16  number of captured frames, wraps modulo 2^16.
REQ-020 err_partial  out  1  sticky; set when a frame ends with a partial word.
REQ-021 err_early  out  1  sticky; set when an in-window pixel arrives before write_req_ack.

Function
REQ-022 SHALL detect the vsync rising edge from a one-cycle registered copy of cmos_frame_vsync.
REQ-023 SHALL latch all cfg_* inputs on each vsync rising edge; cfg changes mid-frame have no effect on the current frame.
REQ-024 SHALL implement states IDLE, REQ, CAPTURE.
REQ-025 IDLE->REQ on a vsync rising edge when skip_cnt==0; then skip_cnt loads the latched cfg_skip. When skip_cnt!=0, skip_cnt decrements and the state stays IDLE.
REQ-026 In REQ, write_req SHALL be 1; on the first cycle write_req_ack==1 the block goes to CAPTURE and write_req is 0 from the next cycle.
REQ-027 In CAPTURE, a vsync rising edge SHALL end the frame: flush, then frame_done=1 for one cycle, frame_cnt+1, and a same-cycle re-evaluation of REQ-025 for the new frame.
REQ-028 Column counter: +1 per valid cycle while href=1; cleared on the href falling edge. Row counter: +1 on the href falling edge. Both are cleared on a vsync rising edge.
REQ-029 A pixel is in-window when h_start <= col < h_start+h_len and v_start <= row < v_start+v_len; sums are CNT_W+1 bits, so there is no wrap.
REQ-030 h_len==0 or v_len==0 SHALL produce no write_en for the frame; frame_done still pulses.
REQ-031 In-window pixels in CAPTURE SHALL shift into a pack register; the first pixel of a word occupies write_data[MEM_W-1 -: PIX_W].
REQ-032 write_en SHALL assert the cycle after the valid that completes the K-th pixel, with write_data held until the next write_en.
REQ-033 If K==1, every in-window pixel SHALL produce write_en one cycle later.
REQ-034 Flush: a pending partial word SHALL be emitted left-aligned and zero-padded with write_en=1, and err_partial set; frame_done follows on the next cycle.
REQ-035 In-window pixels in IDLE or REQ SHALL be discarded; in REQ they also set err_early.
REQ-036 A vsync rising edge while in REQ SHALL keep write_req asserted and treat the next frame as current, with no frame_done.

Reset
REQ-037 rst SHALL force state IDLE; write_req, write_en, frame_done, err_partial, err_early = 0; write_data, frame_cnt, counters, skip_cnt, pack register = 0.
REQ-038 Reset asserted mid-frame SHALL abandon the frame without flush; after release, capture restarts at the next vsync rising edge.

Verification
REQ-039 Defaults, window 0/8 x 0/2, ack 2 cycles after req, 8-pixel lines with pixels 0x0001..0x0008 -> 4 write_en per line, first word 0x00010002, frame_done once, frame_cnt=1.
REQ-040 cfg_skip=2, 6 frames -> frames 1 and 4 captured, frame_cnt=2, write_req asserted exactly twice.
REQ-041 Window h 3/5, line of 8 pixels -> words {p3,p4},{p5,p6}, then flush {p7,0x0000} at vsync, err_partial=1.
REQ-042 Ack delayed past the first in-window pixel -> that pixel is not written, err_early=1, capture resumes after the ack.
REQ-043 PIX_W=8, MEM_W=32, pixels 0xA1..0xA4 -> write_data 0xA1A2A3A4.
REQ-044 rst pulse mid-line, then a fresh frame -> all outputs 0 during reset, and the next frame is captured correctly from its first pixel.

Source files
------------

// File: rtl/cmos_frame_packer.sv
// Crops a CMOS camera stream to a window, drops frames by a decimation count
// and packs the surviving pixels into MEM_W-bit words for a frame-buffer writer.
module cmos_frame_packer #(
    parameter int PIX_W  = 16,
    parameter int MEM_W  = 32,
    parameter int CNT_W  = 12,
    parameter int SKIP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmos_frame_vsync,
    input  logic              cmos_frame_href,
    input  logic              cmos_frame_valid,
    input  logic [PIX_W-1:0]  cmos_frame_data,
    input  logic [CNT_W-1:0]  cfg_h_start,
    input  logic [CNT_W-1:0]  cfg_h_len,
    input  logic [CNT_W-1:0]  cfg_v_start,
    input  logic [CNT_W-1:0]  cfg_v_len,
    input  logic [SKIP_W-1:0] cfg_skip,
    output logic              write_req,
    input  logic              write_req_ack,
    output logic              write_en,
    output logic [MEM_W-1:0]  write_data,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic              err_partial,
    output logic              err_early
);

    localparam int K    = MEM_W / PIX_W;
    localparam int PC_W = (K > 1) ? $clog2(K) : 1;

    if (((MEM_W % PIX_W) != 0) || (MEM_W < PIX_W)) begin : g_bad_mem_w
        $error("cmos_frame_packer: MEM_W must be an integer multiple of PIX_W");
    end

    // state      | meaning
    // ST_IDLE    | waiting for a frame start; also where skipped frames pass by
    // ST_REQ     | write_req high, waiting for the frame buffer to accept
    // ST_CAPTURE | cropping and packing pixels until the next frame start
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              vsync_q;
    logic              href_q;
    logic [CNT_W-1:0]  h_start_q, h_start_d;
    logic [CNT_W-1:0]  h_len_q, h_len_d;
    logic [CNT_W-1:0]  v_start_q, v_start_d;
    logic [CNT_W-1:0]  v_len_q, v_len_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic [MEM_W-1:0]  pack_q, pack_d;
    logic [PC_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic              write_en_q, write_en_d;
    logic [MEM_W-1:0]  write_data_q, write_data_d;
    logic              done_pend_q, done_pend_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              err_partial_q, err_partial_d;
    logic              err_early_q, err_early_d;

    logic              vs_rise;
    logic              href_fall;
    logic              pix_vld;
    logic [CNT_W:0]    h_end;
    logic [CNT_W:0]    v_end;
    logic              in_win;
    logic [MEM_W-1:0]  pack_shift;
    logic [31:0]       flush_sh;
    logic [MEM_W-1:0]  flush_word;

    assign vs_rise   = cmos_frame_vsync & ~vsync_q;
    assign href_fall = href_q & ~cmos_frame_href;
    // A pixel coinciding with a frame start belongs to neither frame.
    assign pix_vld   = cmos_frame_href & cmos_frame_valid & ~vs_rise;

    assign h_end  = {1'b0, h_start_q} + {1'b0, h_len_q};
    assign v_end  = {1'b0, v_start_q} + {1'b0, v_len_q};
    assign in_win = pix_vld
                  && (col_q >= h_start_q) && ({1'b0, col_q} < h_end)
                  && (row_q >= v_start_q) && ({1'b0, row_q} < v_end);

    // Oldest pixel drifts to the top of the word as later pixels shift in.
    assign pack_shift = (pack_q << PIX_W) | MEM_W'(cmos_frame_data);
    assign flush_sh   = 32'(PIX_W * (K - int'(pix_cnt_q)));
    assign flush_word = pack_q << flush_sh;

    always_comb begin
        state_d       = state_q;
        h_start_d     = h_start_q;
        h_len_d       = h_len_q;
        v_start_d     = v_start_q;
        v_len_d       = v_len_q;
        skip_d        = skip_q;
        col_d         = col_q;
        row_d         = row_q;
        pack_d        = pack_q;
        pix_cnt_d     = pix_cnt_q;
        write_en_d    = 1'b0;
        write_data_d  = write_data_q;
        done_pend_d   = done_pend_q;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        err_partial_d = err_partial_q;
        err_early_d   = err_early_q;

        if (vs_rise) begin
            h_start_d = cfg_h_start;
            h_len_d   = cfg_h_len;
            v_start_d = cfg_v_start;
            v_len_d   = cfg_v_len;
            col_d     = '0;
            row_d     = '0;
        end else if (href_fall) begin
            col_d = '0;
            if (row_q != '1) row_d = row_q + CNT_W'(1);
        end else if (cmos_frame_href && cmos_frame_valid && (col_q != '1)) begin
            // Counters saturate so an overlong line can never wrap back into the window.
            col_d = col_q + CNT_W'(1);
        end

        if (done_pend_q) begin
            done_pend_d  = 1'b0;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (vs_rise) begin
                    if (skip_q == '0) begin
                        state_d = ST_REQ;
                        skip_d  = cfg_skip;
                    end else begin
                        skip_d  = skip_q - SKIP_W'(1);
                    end
                end
            end

            ST_REQ: begin
                if (write_req_ack) state_d = ST_CAPTURE;
                if (in_win)        err_early_d = 1'b1;
            end

            ST_CAPTURE: begin
                if (vs_rise) begin
                    if (pix_cnt_q != '0) begin
                        write_en_d    = 1'b1;
                        write_data_d  = flush_word;
                        err_partial_d = 1'b1;
                        done_pend_d   = 1'b1;
                    end else begin
                        frame_done_d  = 1'b1;
                        frame_cnt_d   = frame_cnt_q + 16'd1;
                    end
                    pack_d    = '0;
                    pix_cnt_d = '0;
                    if (skip_q == '0) begin
                        state_d = ST_REQ;
                        skip_d  = cfg_skip;
                    end else begin
                        state_d = ST_IDLE;
                        skip_d  = skip_q - SKIP_W'(1);
                    end
                end else if (in_win) begin
                    if (pix_cnt_q == PC_W'(K - 1)) begin
                        write_en_d   = 1'b1;
                        write_data_d = pack_shift;
                        pack_d       = '0;
                        pix_cnt_d    = '0;
                    end else begin
                        pack_d    = pack_shift;
                        pix_cnt_d = pix_cnt_q + PC_W'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            h_start_q     <= '0;
            h_len_q       <= '0;
            v_start_q     <= '0;
            v_len_q       <= '0;
            skip_q        <= '0;
            col_q         <= '0;
            row_q         <= '0;
            pack_q        <= '0;
            pix_cnt_q     <= '0;
            write_en_q    <= 1'b0;
            write_data_q  <= '0;
            done_pend_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            err_partial_q <= 1'b0;
            err_early_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= cmos_frame_vsync;
            href_q        <= cmos_frame_href;
            h_start_q     <= h_start_d;
            h_len_q       <= h_len_d;
            v_start_q     <= v_start_d;
            v_len_q       <= v_len_d;
            skip_q        <= skip_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pack_q        <= pack_d;
            pix_cnt_q     <= pix_cnt_d;
            write_en_q    <= write_en_d;
            write_data_q  <= write_data_d;
            done_pend_q   <= done_pend_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
            err_partial_q <= err_partial_d;
            err_early_q   <= err_early_d;
        end
    end

    assign write_req   = (state_q == ST_REQ);
    assign write_en    = write_en_q;
    assign write_data  = write_data_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_partial = err_partial_q;
    assign err_early   = err_early_q;

endmodule

// File: tb/tb_cmos_frame_packer.sv
// Directed bench for cmos_frame_packer: a 16-bit-pixel instance plus an
// 8-bit-pixel instance sharing the same sync and control stimulus.
module tb_cmos_frame_packer;

    localparam int CNT_W  = 12;
    localparam int SKIP_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              vsync, href, valid, ack;
    logic [15:0]       data;
    logic [7:0]        data8;
    logic [CNT_W-1:0]  h_start, h_len, v_start, v_len;
    logic [SKIP_W-1:0] skip;

    logic              write_req, write_en, frame_done, err_partial, err_early;
    logic [31:0]       write_data;
    logic [15:0]       frame_cnt;
    logic              write_req8, write_en8, frame_done8, err_partial8, err_early8;
    logic [31:0]       write_data8;
    logic [15:0]       frame_cnt8;

    always #5 clk = ~clk;

    cmos_frame_packer u_dut (
        .clk(clk), .rst(rst),
        .cmos_frame_vsync(vsync), .cmos_frame_href(href),
        .cmos_frame_valid(valid), .cmos_frame_data(data),
        .cfg_h_start(h_start), .cfg_h_len(h_len),
        .cfg_v_start(v_start), .cfg_v_len(v_len), .cfg_skip(skip),
        .write_req(write_req), .write_req_ack(ack),
        .write_en(write_en), .write_data(write_data),
        .frame_done(frame_done), .frame_cnt(frame_cnt),
        .err_partial(err_partial), .err_early(err_early)
    );

    cmos_frame_packer #(.PIX_W(8), .MEM_W(32)) u_dut8 (
        .clk(clk), .rst(rst),
        .cmos_frame_vsync(vsync), .cmos_frame_href(href),
        .cmos_frame_valid(valid), .cmos_frame_data(data8),
        .cfg_h_start(h_start), .cfg_h_len(h_len),
        .cfg_v_start(v_start), .cfg_v_len(v_len), .cfg_skip(skip),
        .write_req(write_req8), .write_req_ack(ack),
        .write_en(write_en8), .write_data(write_data8),
        .frame_done(frame_done8), .frame_cnt(frame_cnt8),
        .err_partial(err_partial8), .err_early(err_early8)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // monitor: records write words, frame_done pulses and write_req rises
    logic [31:0] words[$];
    logic [31:0] words8[$];
    int   n_done = 0, n_req = 0, cyc = 0, last_we_cyc = 0, last_done_cyc = 0;
    logic req_prev = 1'b0;
    logic mon_clr  = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_clr) begin
                words.delete();
                words8.delete();
                n_done = 0;
                n_req  = 0;
            end else begin
                if (write_en) begin
                    words.push_back(write_data);
                    last_we_cyc = cyc;
                end
                if (write_en8) words8.push_back(write_data8);
                if (frame_done) begin
                    n_done++;
                    last_done_cyc = cyc;
                end
                if (write_req && !req_prev) n_req++;
            end
            req_prev = write_req;
        end
    end

    // frame buffer model: acks two cycles after write_req, or follows ack_force
    logic ack_auto  = 1'b1;
    logic ack_force = 1'b0;
    int   req_age   = 0;

    initial begin
        ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ack_auto) begin
                ack = 1'b0;
                if (write_req) begin
                    req_age++;
                    if (req_age == 2) ack = 1'b1;
                end else begin
                    req_age = 0;
                end
            end else begin
                ack     = ack_force;
                req_age = 0;
            end
        end
    end

    function automatic logic [31:0] word_at(input int idx);
        return (idx < words.size()) ? words[idx] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] word8_at(input int idx);
        return (idx < words8.size()) ? words8[idx] : 32'hDEAD_BEEF;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick(1);
        mon_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        valid = 1'b0;
        data  = '0;
        data8 = '0;
        ack_auto  = 1'b1;
        ack_force = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic set_cfg(input int hs, input int hl, input int vs, input int vl, input int sk);
        h_start = CNT_W'(hs);
        h_len   = CNT_W'(hl);
        v_start = CNT_W'(vs);
        v_len   = CNT_W'(vl);
        skip    = SKIP_W'(sk);
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(6);
    endtask

    task automatic put_pixel(input logic [15:0] val);
        valid = 1'b1;
        data  = val;
        data8 = 8'(8'hA0 + val[7:0]);
        tick(1);
        valid = 1'b0;
    endtask

    task automatic send_line(input int n, input logic [15:0] base);
        href = 1'b1;
        tick(1);
        for (int i = 0; i < n; i++) put_pixel(base + 16'(i));
        href = 1'b0;
        data = '0;
        tick(3);
    endtask

    initial begin
        set_cfg(0, 8, 0, 2, 0);
        do_reset();

        // reset values
        chk("rst_write_req",   32'(write_req),   32'd0);
        chk("rst_write_en",    32'(write_en),    32'd0);
        chk("rst_write_data",  write_data,       32'd0);
        chk("rst_frame_done",  32'(frame_done),  32'd0);
        chk("rst_frame_cnt",   32'(frame_cnt),   32'd0);
        chk("rst_err_partial", 32'(err_partial), 32'd0);
        chk("rst_err_early",   32'(err_early),   32'd0);

        // full-width window, 2 rows; third line lies below the window
        clear_mon();
        frame_start();
        send_line(8, 16'h0001);
        send_line(8, 16'h0001);
        send_line(8, 16'h0001);
        frame_start();
        tick(4);
        chk("a_nwords",    32'(words.size()), 32'd8);
        chk("a_word0",     word_at(0), 32'h0001_0002);
        chk("a_word3",     word_at(3), 32'h0007_0008);
        chk("a_word7",     word_at(7), 32'h0007_0008);
        chk("a_ndone",     32'(n_done),      32'd1);
        chk("a_frame_cnt", 32'(frame_cnt),   32'd1);
        chk("a_partial",   32'(err_partial), 32'd0);
        chk("a_early",     32'(err_early),   32'd0);
        chk("p8_nwords",   32'(words8.size()), 32'd4);
        chk("p8_word0",    word8_at(0), 32'hA1A2_A3A4);
        chk("p8_word1",    word8_at(1), 32'hA5A6_A7A8);

        // decimation: skip 2 frames after each captured one
        set_cfg(0, 8, 0, 1, 2);
        do_reset();
        clear_mon();
        for (int f = 0; f < 6; f++) begin
            frame_start();
            send_line(8, 16'h0001);
        end
        tick(4);
        chk("b_frame_cnt", 32'(frame_cnt),    32'd2);
        chk("b_nreq",      32'(n_req),        32'd2);
        chk("b_ndone",     32'(n_done),       32'd2);
        chk("b_nwords",    32'(words.size()), 32'd8);

        // horizontal crop 3/5 with a partial word flushed at frame end
        set_cfg(3, 5, 0, 1, 0);
        do_reset();
        clear_mon();
        frame_start();
        send_line(8, 16'h0100);
        chk("c_nwords_pre",  32'(words.size()), 32'd2);
        chk("c_partial_pre", 32'(err_partial),  32'd0);
        frame_start();
        tick(3);
        chk("c_word0",     word_at(0), 32'h0103_0104);
        chk("c_word1",     word_at(1), 32'h0105_0106);
        chk("c_flush",     word_at(2), 32'h0107_0000);
        chk("c_partial",   32'(err_partial), 32'd1);
        chk("c_ndone",     32'(n_done),      32'd1);
        chk("c_done_gap",  32'(last_done_cyc - last_we_cyc), 32'd1);

        // ack arrives after the first in-window pixel
        set_cfg(0, 8, 0, 1, 0);
        do_reset();
        ack_auto = 1'b0;
        clear_mon();
        frame_start();
        href = 1'b1;
        put_pixel(16'h0001);
        ack_force = 1'b1;
        tick(2);
        ack_force = 1'b0;
        tick(2);
        for (int i = 2; i <= 8; i++) put_pixel(16'(i));
        href = 1'b0;
        tick(3);
        frame_start();
        tick(3);
        chk("d_early",   32'(err_early),    32'd1);
        chk("d_nwords",  32'(words.size()), 32'd4);
        chk("d_word0",   word_at(0), 32'h0002_0003);
        chk("d_flush",   word_at(3), 32'h0008_0000);
        ack_auto = 1'b1;

        // reset in the middle of a line
        set_cfg(0, 8, 0, 1, 0);
        do_reset();
        frame_start();
        send_line(3, 16'h0001);
        frame_start();
        href = 1'b1;
        tick(1);
        put_pixel(16'h0001);
        put_pixel(16'h0002);
        put_pixel(16'h0003);
        tick(1);
        chk("f_pre_data",  write_data,       32'h0001_0002);
        chk("f_pre_cnt",   32'(frame_cnt),   32'd1);
        rst = 1'b1;
        tick(1);
        chk("f_rst_req",     32'(write_req),   32'd0);
        chk("f_rst_en",      32'(write_en),    32'd0);
        chk("f_rst_data",    write_data,       32'd0);
        chk("f_rst_done",    32'(frame_done),  32'd0);
        chk("f_rst_cnt",     32'(frame_cnt),   32'd0);
        chk("f_rst_partial", 32'(err_partial), 32'd0);
        chk("f_rst_early",   32'(err_early),   32'd0);
        tick(2);
        rst = 1'b0;
        put_pixel(16'h0004);
        put_pixel(16'h0005);
        href = 1'b0;
        tick(3);
        clear_mon();
        frame_start();
        send_line(8, 16'h0001);
        frame_start();
        tick(4);
        chk("f_nwords",    32'(words.size()), 32'd4);
        chk("f_word0",     word_at(0), 32'h0001_0002);
        chk("f_word3",     word_at(3), 32'h0007_0008);
        chk("f_frame_cnt", 32'(frame_cnt),   32'd1);
        chk("f_partial",   32'(err_partial), 32'd0);

        // zero-length window: nothing written, frame still completes
        set_cfg(0, 0, 0, 1, 0);
        do_reset();
        clear_mon();
        frame_start();
        send_line(8, 16'h0001);
        frame_start();
        tick(3);
        chk("g_nwords", 32'(words.size()), 32'd0);
        chk("g_ndone",  32'(n_done),       32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule
